// File: rtl/fc_mac_pkg.sv
// rtl/fc_mac_pkg.sv - shared defaults, FSM state type and clog2 helper for the FC MAC engine
package fc_mac_pkg;

  localparam int MAC_NUM_DEF      = 20;
  localparam int DATA_WIDTH_DEF   = 8;
  localparam int WEIGHT_WIDTH_DEF = 4;
  localparam int ACC_WIDTH_DEF    = 32;
  localparam int OUT_WIDTH_DEF    = 8;
  localparam int OUT_SHIFT_DEF    = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fc_adder_tree.sv
// rtl/fc_adder_tree.sv - registered signed reduction of N packed lanes (stage 2)
module fc_adder_tree
  import fc_mac_pkg::*;
#(
  parameter int N     = MAC_NUM_DEF,
  parameter int IN_W  = DATA_WIDTH_DEF + WEIGHT_WIDTH_DEF,
  parameter int OUT_W = IN_W + clog2(N)
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              en,
  input  logic [N*IN_W-1:0] in_vec,
  output logic [OUT_W-1:0]  sum_q
);

  logic [OUT_W-1:0] sum_d;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) begin
      sum_d = sum_d + OUT_W'($signed(in_vec[i*IN_W +: IN_W]));
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/fc_mac_engine.sv
// rtl/fc_mac_engine.sv - fully-connected MAC engine: multiply, reduce, accumulate per neuron, shift/ReLU/clamp
module fc_mac_engine
  import fc_mac_pkg::*;
#(
  parameter int MAC_NUM      = MAC_NUM_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter int OUT_WIDTH    = OUT_WIDTH_DEF,
  parameter int OUT_SHIFT    = OUT_SHIFT_DEF
) (
  input  logic                            clk,
  input  logic                            srstn,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [MAC_NUM*DATA_WIDTH-1:0]   in_data,
  input  logic [MAC_NUM*WEIGHT_WIDTH-1:0] in_weight,
  input  logic                            in_last,
  input  logic [ACC_WIDTH-1:0]            bias,
  input  logic                            relu_en,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_WIDTH-1:0]            out_data,
  output logic                            out_sat,
  output logic [15:0]                     beat_cnt
);

  localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int SUM_W  = PROD_W + clog2(MAC_NUM);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ACC_WIDTH'(-(1 << (OUT_WIDTH-1)));

  logic en, beat;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [MAC_NUM*PROD_W-1:0] s1_prod_q, s1_prod_d;
  logic s1_vld_q, s1_vld_d, s1_last_q, s1_last_d, s1_first_q, s1_first_d, s1_relu_q, s1_relu_d;
  logic [ACC_WIDTH-1:0] s1_bias_q, s1_bias_d;
  logic [SUM_W-1:0] s2_sum;
  logic s2_vld_q, s2_vld_d, s2_last_q, s2_last_d, s2_first_q, s2_first_d, s2_relu_q, s2_relu_d;
  logic [ACC_WIDTH-1:0] s2_bias_q, s2_bias_d;
  state_t state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_base;
  logic signed [ACC_WIDTH:0] acc_sum;
  logic load, sat_q, sat_d, done_q, done_d, fin_relu_q, fin_relu_d;
  logic signed [ACC_WIDTH-1:0] res_shift, res_relu;
  logic out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;

  // A held result freezes every stage, so nothing in flight is ever dropped.
  assign en        = !(out_valid_q && !out_ready);
  assign beat      = in_valid && en;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign beat_cnt  = beat_cnt_q;

  always_comb begin
    s1_prod_d  = s1_prod_q;
    s1_vld_d   = s1_vld_q;
    s1_last_d  = s1_last_q;
    s1_first_d = s1_first_q;
    s1_relu_d  = s1_relu_q;
    s1_bias_d  = s1_bias_q;
    beat_cnt_d = beat_cnt_q;
    if (en) begin
      s1_vld_d   = in_valid;
      s1_last_d  = in_last;
      s1_first_d = (beat_cnt_q == 16'd0);
      s1_relu_d  = relu_en;
      s1_bias_d  = bias;
      for (int i = 0; i < MAC_NUM; i++) begin
        s1_prod_d[i*PROD_W +: PROD_W] =
          PROD_W'($signed(in_data[(MAC_NUM-1-i)*DATA_WIDTH +: DATA_WIDTH])) *
          PROD_W'($signed(in_weight[(MAC_NUM-1-i)*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
      end
    end
    if (beat) begin
      beat_cnt_d = in_last ? 16'd0 : ((beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1);
    end
  end

  fc_adder_tree #(.N(MAC_NUM), .IN_W(PROD_W), .OUT_W(SUM_W)) u_tree (
    .clk    (clk),
    .srstn  (srstn),
    .en     (en),
    .in_vec (s1_prod_q),
    .sum_q  (s2_sum)
  );

  always_comb begin
    s2_vld_d   = en ? s1_vld_q   : s2_vld_q;
    s2_last_d  = en ? s1_last_q  : s2_last_q;
    s2_first_d = en ? s1_first_q : s2_first_q;
    s2_relu_d  = en ? s1_relu_q  : s2_relu_q;
    s2_bias_d  = en ? s1_bias_q  : s2_bias_q;
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    done_d     = done_q;
    fin_relu_d = fin_relu_q;
    load       = (state_q == ST_IDLE) || s2_first_q;
    acc_base   = load ? s2_bias_q : acc_q;
    acc_sum    = $signed({acc_base[ACC_WIDTH-1], acc_base}) + (ACC_WIDTH+1)'($signed(s2_sum));
    if (en) begin
      done_d = s2_vld_q && s2_last_q;
      if (s2_vld_q) begin
        fin_relu_d = s2_relu_q;
        state_d    = s2_last_q ? ST_IDLE : ST_RUN;
        sat_d      = load ? 1'b0 : sat_q;
        if (acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1]) begin
          sat_d = 1'b1;
          acc_d = acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
          acc_d = acc_sum[ACC_WIDTH-1:0];
        end
      end
    end
  end

  // Output stage reads the completed accumulator one cycle after it settles.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    res_shift   = $signed(acc_q) >>> OUT_SHIFT;
    res_relu    = (fin_relu_q && (res_shift < 0)) ? '0 : res_shift;
    if (en) begin
      out_valid_d = done_q;
      if (done_q) begin
        out_sat_d = sat_q;
        if (res_relu > OUT_MAX) begin
          out_data_d = OUT_MAX[OUT_WIDTH-1:0];
          out_sat_d  = 1'b1;
        end else if (res_relu < OUT_MIN) begin
          out_data_d = OUT_MIN[OUT_WIDTH-1:0];
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = res_relu[OUT_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      beat_cnt_q  <= '0;
      s1_prod_q   <= '0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_relu_q   <= 1'b0;
      s1_bias_q   <= '0;
      s2_vld_q    <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_relu_q   <= 1'b0;
      s2_bias_q   <= '0;
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      done_q      <= 1'b0;
      fin_relu_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      s1_prod_q   <= s1_prod_d;
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      s1_first_q  <= s1_first_d;
      s1_relu_q   <= s1_relu_d;
      s1_bias_q   <= s1_bias_d;
      s2_vld_q    <= s2_vld_d;
      s2_last_q   <= s2_last_d;
      s2_first_q  <= s2_first_d;
      s2_relu_q   <= s2_relu_d;
      s2_bias_q   <= s2_bias_d;
      state_q     <= state_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      done_q      <= done_d;
      fin_relu_q  <= fin_relu_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_fc_mac_engine.sv
// tb/tb_fc_mac_engine.sv - directed and randomized checks of fc_mac_engine against an integer neuron model
module tb_fc_mac_engine;

  localparam int N = 20;
  localparam longint ACC_MAX = 64'sd2147483647;
  localparam longint ACC_MIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         srstn;
  logic         in_valid;
  logic         in_ready;
  logic [159:0] in_data;
  logic [79:0]  in_weight;
  logic         in_last;
  logic [31:0]  bias;
  logic         relu_en;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         out_sat;
  logic [15:0]  beat_cnt;

  fc_mac_engine dut (
    .clk       (clk),
    .srstn     (srstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_weight (in_weight),
    .in_last   (in_last),
    .bias      (bias),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    longint sat;
  } res_t;

  res_t   exp_q[$];
  int     pop_cyc[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc    = 0;
  int     n_push = 0;
  int     n_pop  = 0;
  longint m_acc;
  bit     m_open;
  bit     m_sat;
  longint cur_bias;
  bit     cur_relu;
  bit     rand_ready = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every transferred result must match the model's next neuron.
  always @(negedge clk) begin
    res_t e;
    #3;
    if (srstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_pop++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", longint'($signed(out_data)), e.data);
        chk("out_sat", longint'(out_sat), e.sat);
      end
    end
  end

  task automatic beat(input bit last, input bit rnd, input int dval, input int wval);
    logic [159:0] dpk;
    logic [79:0]  wpk;
    longint s, r;
    int dv, wv, n;
    res_t e;
    s = 0;
    for (int i = 0; i < N; i++) begin
      dv = rnd ? int'($urandom_range(255)) - 128 : dval;
      wv = rnd ? int'($urandom_range(15)) - 8 : wval;
      s  = s + longint'(dv * wv);
      dpk[(N-1-i)*8 +: 8] = 8'(dv);
      wpk[(N-1-i)*4 +: 4] = 4'(wv);
    end
    in_valid  = 1'b1;
    in_data   = dpk;
    in_weight = wpk;
    in_last   = last;
    bias      = m_open ? 32'($urandom) : 32'(cur_bias);
    relu_en   = last ? cur_relu : 1'($urandom);
    if (rand_ready) out_ready = ($urandom_range(3) != 0);
    #1;
    n = 0;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 1, 0);
        break;
      end
    end
    if (!m_open) begin
      m_acc = cur_bias;
      m_sat = 1'b0;
    end
    m_acc = m_acc + s;
    if (m_acc > ACC_MAX) begin
      m_acc = ACC_MAX;
      m_sat = 1'b1;
    end else if (m_acc < ACC_MIN) begin
      m_acc = ACC_MIN;
      m_sat = 1'b1;
    end
    m_open = !last;
    if (last) begin
      r = m_acc >>> 4;
      if (cur_relu && r < 0) r = 0;
      e.sat = m_sat;
      if (r > 127) begin
        r = 127;
        e.sat = 1;
      end else if (r < -128) begin
        r = -128;
        e.sat = 1;
      end
      e.data = r;
      exp_q.push_back(e);
      n_push++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    #1;
    while (out_valid !== 1'b1) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 50) begin
        chk("out_valid_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_done", longint'(n < 100), 1);
  endtask

  initial begin
    int nb, sel;
    srstn = 1'b0; in_valid = 1'b0; in_data = '0; in_weight = '0; in_last = 1'b0;
    bias = '0; relu_en = 1'b0; out_ready = 1'b1;
    m_open = 1'b0; m_acc = 0; m_sat = 1'b0; cur_bias = 0; cur_relu = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    srstn = 1'b1;
    @(negedge clk);

    // single all-ones beat, three-cycle latency
    cur_bias = 0; cur_relu = 1'b0;
    beat(1'b1, 1'b0, 1, 1);
    idle(0);
    #1 chk("lat_e0_valid", out_valid, 0);
    @(negedge clk); #1 chk("lat_e1_valid", out_valid, 0);
    @(negedge clk); #1 chk("lat_e2_valid", out_valid, 0);
    @(negedge clk); #1 chk("lat_e3_valid", out_valid, 1);
    chk("ones_data", longint'($signed(out_data)), 1);
    chk("ones_sat", out_sat, 0);
    drain();

    // output clamp on a large positive neuron
    cur_bias = -100; cur_relu = 1'b0;
    for (int i = 0; i < 3; i++) beat(i == 2, 1'b0, 127, 7);
    idle(0); wait_out();
    chk("clamp_data", longint'($signed(out_data)), 127);
    chk("clamp_sat", out_sat, 1);
    drain();

    // negative neuron with and without ReLU
    cur_bias = 0; cur_relu = 1'b1;
    beat(1'b1, 1'b0, -8, 1);
    idle(0); wait_out();
    chk("relu_data", longint'($signed(out_data)), 0);
    chk("relu_sat", out_sat, 0);
    drain();
    cur_relu = 1'b0;
    beat(1'b1, 1'b0, -8, 1);
    idle(0); wait_out();
    chk("neg_data", longint'($signed(out_data)), -10);
    drain();

    // accumulator saturation, high then low (sat sticks through ReLU zeroing)
    cur_bias = ACC_MAX - 100; cur_relu = 1'b0;
    beat(1'b0, 1'b0, 127, 7);
    beat(1'b1, 1'b0, -128, 7);
    idle(0); wait_out();
    chk("accsat_hi_data", longint'($signed(out_data)), 127);
    chk("accsat_hi_sat", out_sat, 1);
    drain();
    cur_bias = ACC_MIN + 100; cur_relu = 1'b1;
    beat(1'b0, 1'b0, -128, 7);
    beat(1'b1, 1'b0, 127, 7);
    idle(0); wait_out();
    chk("accsat_lo_data", longint'($signed(out_data)), 0);
    chk("accsat_lo_sat", out_sat, 1);
    drain();

    // consumer stall: pipeline and input freeze, nothing lost on release
    out_ready = 1'b0; cur_bias = 37; cur_relu = 1'b0;
    beat(1'b1, 1'b1, 0, 0);
    idle(0); wait_out();
    in_valid = 1'b1; in_last = 1'b1; in_data = {5{32'($urandom)}};
    repeat (5) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", longint'($signed(out_data)), exp_q.size() > 0 ? exp_q[0].data : 999);
      @(negedge clk); #1;
    end
    cur_bias = -55;
    beat(1'b1, 1'b1, 0, 0);
    drain();
    chk("stall_results", n_pop, n_push);

    // reset in the middle of a group
    cur_bias = 1234; cur_relu = 1'b0;
    beat(1'b0, 1'b1, 0, 0);
    beat(1'b0, 1'b1, 0, 0);
    idle(0);
    #1 chk("mid_beat_cnt", beat_cnt, 2);
    srstn = 1'b0;
    #2 chk("inrst_beat_cnt", beat_cnt, 0);
    @(negedge clk);
    srstn = 1'b1; m_open = 1'b0; m_acc = 0; m_sat = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_beat_cnt", beat_cnt, 0);
    repeat (4) @(negedge clk);
    #1 chk("post_rst_no_output", out_valid, 0);
    cur_bias = 0;
    beat(1'b1, 1'b0, 1, 1);
    idle(0); wait_out();
    chk("post_rst_data", longint'($signed(out_data)), 1);
    drain();

    // back-to-back single-beat neurons drain one per cycle
    pop_cyc.delete();
    for (int g = 0; g < 6; g++) begin
      cur_bias = longint'($urandom_range(400)) - 200;
      cur_relu = 1'($urandom);
      beat(1'b1, 1'b1, 0, 0);
    end
    drain();
    chk("b2b_count", pop_cyc.size(), 6);
    for (int k = 1; k < pop_cyc.size(); k++) chk("b2b_gap", pop_cyc[k] - pop_cyc[k-1], 1);

    // randomized groups, bubbles and backpressure
    rand_ready = 1'b1;
    for (int g = 0; g < 30; g++) begin
      nb  = int'($urandom_range(1, 4));
      sel = int'($urandom_range(9));
      if (sel == 0)      cur_bias = ACC_MAX - longint'($urandom_range(20000));
      else if (sel == 1) cur_bias = ACC_MIN + longint'($urandom_range(20000));
      else               cur_bias = longint'($urandom_range(4000)) - 2000;
      cur_relu = 1'($urandom);
      for (int b = 0; b < nb; b++) begin
        beat(b == nb - 1, 1'b1, 0, 0);
        if ($urandom_range(2) == 0) idle(int'($urandom_range(1, 2)));
      end
    end
    rand_ready = 1'b0;
    drain();
    chk("total_results", n_pop, n_push);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=still_running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/fc_mac_engine.md
FC_MAC_ENGINE -- requirements
Module: fc_mac_engine

Interface
REQ-001 Parameter MAC_NUM, 20, number of parallel lanes per beat.
REQ-002 Parameter DATA_WIDTH, 8, activation width, signed two's complement.
REQ-003 Parameter WEIGHT_WIDTH, 4, weight width, signed two's complement.
REQ-004 Parameter ACC_WIDTH, 32, accumulator width, signed.
REQ-005 Parameter OUT_WIDTH, 8, result width, signed.
REQ-006 Parameter OUT_SHIFT, 4, arithmetic right shift applied before output saturation.
REQ-007 Clocking: one clock; reset is asynchronous and active-low.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 srstn  in  1  asynchronous active-low reset.
REQ-010 in_valid  in  1  beat valid.
REQ-011 in_ready  out  1  engine accepts beat.
REQ-012 in_data  in  MAC_NUM*DATA_WIDTH  activations; lane i = bits [(MAC_NUM-1-i)*DATA_WIDTH +: DATA_WIDTH].
REQ-013 in_weight  in  MAC_NUM*WEIGHT_WIDTH  weights; lane i packed MSB-first as in_data.
REQ-014 in_last  in  1  final beat of one output neuron.
REQ-015 bias  in  ACC_WIDTH  neuron bias, sampled with the first beat of a group.
REQ-016 relu_en  in  1  ReLU mode, sampled with the last beat of a group.
REQ-017 out_valid  out  1  result valid.
REQ-018 out_ready  in  1  consumer accepts result.
REQ-019 out_data  out  OUT_WIDTH  neuron result.
REQ-020 out_sat  out  1  saturation occurred in this group (accumulator or output).
REQ-021 beat_cnt  out  16  beats accepted in the current open group.

Function
REQ-022 Beat transfer SHALL occur when in_valid && in_ready; in_ready = !(out_valid && !out_ready).
REQ-023 When in_ready is low, all pipeline stages SHALL hold (global stall); in_data/in_weight SHALL be ignored.
REQ-024 Stage 1 SHALL register MAC_NUM full-width products (DATA_WIDTH+WEIGHT_WIDTH bits), each with a valid/last/first tag.
REQ-025 Stage 2 SHALL register the sign-extended sum of all products, width DATA_WIDTH+WEIGHT_WIDTH+clog2(MAC_NUM).
REQ-026 Stage 3 FSM states: IDLE (no open group) and RUN (group open).
REQ-027 IDLE: a tagged beat SHALL load acc = bias + sum; go to RUN if not last, else stay IDLE and complete.
REQ-028 RUN: a tagged beat SHALL set acc = acc + sum; a last beat completes and returns to IDLE.
REQ-029 Accumulator adds SHALL saturate to signed ACC_WIDTH limits and set a group-sticky sat flag.
REQ-030 On completion: r = acc >>> OUT_SHIFT (floor); if relu_en and r<0 then r=0; clamp to signed OUT_WIDTH, setting sat on clamp.
REQ-031 out_data/out_sat SHALL register in cycle t+3 when the last beat is accepted at cycle t, with no stalls.
REQ-032 out_valid SHALL stay high with stable out_data until out_ready; a completion in the same cycle as a drain SHALL reload the register without a bubble.
REQ-033 beat_cnt SHALL count accepted beats of the open group, saturate at 65535, and clear on the beat carrying in_last.
REQ-034 Bubbles (no in_valid) between beats SHALL NOT affect the accumulation.

Reset
REQ-035 On srstn low: in_ready=1 after release, out_valid=0, out_data=0, out_sat=0, beat_cnt=0, FSM=IDLE, acc=0, all stage valids=0.
REQ-036 Reset mid-group SHALL discard the partial group; the first beat after release starts a new group with bias.

Structure
REQ-037 Package fc_mac_pkg SHALL hold the parameter defaults, the FSM state enum and a clog2 function.
REQ-038 Sub-module fc_adder_tree SHALL implement the stage-2 pipelined signed reduction, parametrised by MAC_NUM and input width.

Verification
REQ-039 One beat, all data=1, all weights=1, bias=0, last=1, relu_en=0 -> out_data=1 (20>>>4), out_sat=0, latency 3.
REQ-040 Three beats, data=127, weight=7, bias=-100, relu_en=0 -> acc=53240, r=3327 -> out_data=127, out_sat=1.
REQ-041 One beat, data=-8, weight=1, bias=0, relu_en=1 -> out_data=0, out_sat=0; with relu_en=0 -> out_data=-10.
REQ-042 out_ready held low for 5 cycles with a result pending -> in_ready=0, out_data stable, no beats lost after release.
REQ-043 srstn pulse after 2 of 4 beats, then a fresh 1-beat group (all data=1, all weights=1, bias=0) -> out_data=1, beat_cnt=0 after reset.
REQ-044 Back-to-back 1-beat groups with out_ready=1 -> one out_valid per cycle, no bubble.
